// File: rtl/ifm_window_gen.sv
// Streaming 3x3 sliding-window generator feeding the 9-PE array.
// Two line buffers hold the previous rows; a 3x3 register window shifts one column per accepted pixel.
module ifm_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [8:0][DATA_W-1:0]     ifm_window,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      win_valid_q, win_valid_d;
  logic                      frame_done_q, frame_done_d;
  logic [8:0][DATA_W-1:0]    win_q, win_d;

  logic [DATA_W-1:0]         lb0_mem [IMG_W];
  logic [DATA_W-1:0]         lb1_mem [IMG_W];
  logic [DATA_W-1:0]         lb0_rd, lb1_rd;

  logic acc, shift_en, last_col, last_row, emit;

  assign in_ready = !win_valid_q || win_ready;
  assign acc      = in_valid && in_ready;
  // clr wins over acceptance: the pixel presented during clr is dropped entirely.
  assign shift_en = acc && !clr;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign emit     = (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign lb0_rd = lb0_mem[col_q];
  assign lb1_rd = lb1_mem[col_q];

  // Line buffers are never reset; row>=2 guarantees they are rewritten before use.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb1_mem[col_q] <= lb0_rd;
      lb0_mem[col_q] <= in_pixel;
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    if (clr) begin
      col_d       = '0;
      row_d       = '0;
      win_valid_d = 1'b0;
    end else begin
      if (win_ready) begin
        win_valid_d = 1'b0;
      end
      if (acc) begin
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
        if (emit) begin
          win_valid_d = 1'b1;
        end
        frame_done_d = last_col && last_row;
      end
    end
  end

  // Window rows: element r*3+c, r=0 is the oldest row (lb1), c=2 the newest column.
  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3 + 0] = win_q[r*3 + 1];
        win_d[r*3 + 1] = win_q[r*3 + 2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign ifm_window = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ifm_window_gen.sv
// Directed bench for ifm_window_gen on a 4x4 image: full rate, back-pressure, gaps,
// back-to-back frames, mid-frame reset and clr.
module tb_ifm_window_gen;

  typedef logic [8:0][7:0] win_t;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, win_valid, win_ready, frame_done;
  logic [7:0] in_pixel;
  win_t       ifm_window;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  win_t got_q[$];

  always #5 clk = ~clk;

  ifm_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ifm_window (ifm_window),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  // Records every window handed to the consumer and every frame_done pulse.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) got_q.push_back(ifm_window);
    if (rst_n && frame_done) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic win_t mk(input int k, input int off);
    int tab [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                       '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                       '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                       '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
    win_t w;
    for (int j = 0; j < 9; j++) w[j] = 8'(tab[k][j] + off);
    return w;
  endfunction

  // Presents one pixel and returns 1 time unit after the edge that accepted it.
  task automatic send(input int p);
    int  t  = 0;
    bit  ok = 1'b0;
    in_pixel = 8'(p);
    in_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      t++;
    end
    if (!ok) chk("send_timeout", 72'(0), 72'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("pixel %0d accepted=%0d at %0t", p, ok, $time);
  endtask

  task automatic send_frame(input int off, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send(off + i);
    end
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_wins(input string tag, input int nfr, input int off2);
    int n;
    chk({tag, "_count"}, 72'(got_q.size()), 72'(4 * nfr));
    n = (got_q.size() < 4 * nfr) ? got_q.size() : 4 * nfr;
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_win%0d", tag, k), got_q[k], mk(k % 4, (k < 4) ? 0 : off2));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_pixel = '0; win_ready = 1'b1;
    @(negedge clk);
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
    chk("rst_window", ifm_window, 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: full rate
    got_q.delete(); fd_cnt = 0;
    for (int i = 0; i < 10; i++) send(i);
    chk("t1_no_win_before_10", 72'(win_valid), 72'(0));
    send(10);
    chk("t1_latency", 72'(win_valid), 72'(1));
    chk("t1_first_win", ifm_window, mk(0, 0));
    for (int i = 11; i < 16; i++) send(i);
    chk("t1_frame_done", 72'(frame_done), 72'(1));
    drain();
    check_wins("t1", 1, 0);
    chk("t1_fd_count", 72'(fd_cnt), 72'(1));

    // 2: back-pressure after the first window
    got_q.delete();
    win_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(i);
    in_pixel = 8'd11; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t2_in_ready_c%0d", c), 72'(in_ready), 72'(0));
      chk($sformatf("t2_valid_c%0d", c), 72'(win_valid), 72'(1));
      chk($sformatf("t2_hold_c%0d", c), ifm_window, mk(0, 0));
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
    for (int i = 11; i < 16; i++) send(i);
    drain();
    check_wins("t2", 1, 0);

    // 3: random input gaps
    got_q.delete();
    send_frame(0, 1'b1);
    drain();
    check_wins("t3", 1, 0);

    // 4: two back-to-back frames
    got_q.delete(); fd_cnt = 0;
    for (int i = 0; i < 15; i++) send(i);
    chk("t4_fd_before_15", 72'(frame_done), 72'(0));
    send(15);
    chk("t4_fd_after_15", 72'(frame_done), 72'(1));
    for (int i = 100; i < 115; i++) send(i);
    send(115);
    chk("t4_fd_after_115", 72'(frame_done), 72'(1));
    drain();
    check_wins("t4", 2, 100);
    chk("t4_fd_count", 72'(fd_cnt), 72'(2));

    // 5: reset mid-frame
    got_q.delete();
    for (int i = 0; i < 10; i++) send(i);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 72'(win_valid), 72'(0));
    chk("t5_rst_window", ifm_window, 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(0, 1'b0);
    drain();
    check_wins("t5", 1, 0);

    // 6: clr drops pixel 6 and restarts the frame
    got_q.delete();
    for (int i = 0; i < 6; i++) send(i);
    in_pixel = 8'd6; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("t6_clr_valid", 72'(win_valid), 72'(0));
    send_frame(0, 1'b0);
    drain();
    check_wins("t6", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
